led_pattern_ctrl: RTL

//   Sequencer for the 4-LED bank on the board: replaces the free-running LED counter with a

---
 rtl/led_pattern_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl
//   Sequencer for the 4-LED bank. Two debounced push-buttons select the display
//   pattern (up-count, down-count, scan, blink) and the step rate. An internal
//   prescaler generates a base tick every TOP+1 clocks. A small rate counter
//   divides that tick by 1, 2, 4 or 8 to produce the pattern step. Single clock
//   domain. Both button inputs are asynchronous levels and are synchronised here.
//
// Parameters
//   NUM_FF     width of the base prescaler counter
//   TOP        prescaler terminal count (base tick every TOP+1 clocks)
//
// Ports
//   clk        system clock, all logic on posedge
//   rst        synchronous, active-high reset
//   btn_mode   mode button level (debounced, asynchronous)
//   btn_speed  speed button level (debounced, asynchronous)
//   led        LED drive, 1 = on
//   mode       current pattern: 0 UP, 1 DOWN, 2 SCAN, 3 BLINK
//   speed      current rate, step period = (TOP+1) << speed clocks
//   step       one-cycle pulse, high in the cycle led takes a pattern step
//
// The mode register is the controller's state and is visible directly on the
// mode output. The scan direction is the only other piece of state.

module led_pattern_ctrl #(
    parameter int NUM_FF = 25,
    parameter int TOP    = 12499999
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_speed,
    output logic [3:0] led,
    output logic [1:0] mode,
    output logic [1:0] speed,
    output logic       step
);

    typedef enum logic [1:0] {
        MODE_UP    = 2'd0,
        MODE_DOWN  = 2'd1,
        MODE_SCAN  = 2'd2,
        MODE_BLINK = 2'd3
    } mode_t;

    localparam logic [NUM_FF-1:0] TOP_CNT = NUM_FF'(TOP);

    // Bit 0 is the first synchroniser stage and bit 1 is the second.
    logic [1:0]        mode_sync;
    logic [1:0]        speed_sync;
    logic              mode_prev;
    logic              speed_prev;
    logic              mode_evt;
    logic              speed_evt;

    logic [NUM_FF-1:0] pre_cnt;
    logic              base_tick;
    logic [2:0]        rate_cnt;
    logic [2:0]        rate_last;
    logic              step_due;

    mode_t             mode_q;
    mode_t             mode_nxt;
    logic              scan_left;

    assign mode = mode_q;

    assign mode_evt  = mode_sync[1] & ~mode_prev;
    assign speed_evt = speed_sync[1] & ~speed_prev;

    assign base_tick = (pre_cnt == TOP_CNT);
    // Last rate count before a step. The values are 0, 1, 3 and 7, so the step
    // period is (TOP+1) << speed.
    assign rate_last = 3'((4'd1 << speed) - 4'd1);
    assign step_due  = base_tick && (rate_cnt == rate_last);

    assign mode_nxt  = mode_t'(mode_q + 2'd1);

    // Value led reloads to when a pattern is entered.
    function automatic logic [3:0] start_led(input mode_t m);
        logic [3:0] v;
        case (m)
            MODE_UP:    v = 4'b0000;
            MODE_DOWN:  v = 4'b1111;
            MODE_SCAN:  v = 4'b0001;
            MODE_BLINK: v = 4'b0000;
            default:    v = 4'b0000;
        endcase
        return v;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_sync  <= 2'b00;
            speed_sync <= 2'b00;
            mode_prev  <= 1'b0;
            speed_prev <= 1'b0;
            pre_cnt    <= '0;
            rate_cnt   <= 3'd0;
            mode_q     <= MODE_UP;
            speed      <= 2'd0;
            led        <= 4'b0000;
            scan_left  <= 1'b1;
            step       <= 1'b0;
        end else begin
            mode_sync  <= {mode_sync[0], btn_mode};
            speed_sync <= {speed_sync[0], btn_speed};
            mode_prev  <= mode_sync[1];
            speed_prev <= speed_sync[1];
            step       <= 1'b0;

            if (mode_evt || speed_evt) begin
                // A button event restarts the step timebase. It overrides a
                // step that would have fired on the same edge.
                pre_cnt  <= '0;
                rate_cnt <= 3'd0;
                if (speed_evt) begin
                    speed <= speed + 2'd1;
                end
                if (mode_evt) begin
                    mode_q    <= mode_nxt;
                    led       <= start_led(mode_nxt);
                    scan_left <= 1'b1;
                end
            end else begin
                pre_cnt <= base_tick ? '0 : pre_cnt + NUM_FF'(1);
                if (base_tick) begin
                    if (step_due) begin
                        rate_cnt <= 3'd0;
                        step     <= 1'b1;
                        case (mode_q)
                            MODE_UP:    led <= led + 4'd1;
                            MODE_DOWN:  led <= led - 4'd1;
                            MODE_BLINK: led <= ~led;
                            MODE_SCAN: begin
                                // Bounce the lit LED between the two ends. At
                                // an end the direction flips and the LED moves
                                // one position back, so each end is lit for a
                                // single step.
                                case (led)
                                    4'b0001: begin
                                        if (scan_left) begin
                                            led <= 4'b0010;
                                        end else begin
                                            scan_left <= 1'b1;
                                            led       <= 4'b0010;
                                        end
                                    end
                                    4'b0010, 4'b0100: begin
                                        led <= scan_left ? (led << 1) : (led >> 1);
                                    end
                                    4'b1000: begin
                                        if (scan_left) begin
                                            scan_left <= 1'b0;
                                            led       <= 4'b0100;
                                        end else begin
                                            led <= 4'b0100;
                                        end
                                    end
                                    default: begin
                                        // A value that is not one-hot restarts the scan.
                                        led       <= 4'b0001;
                                        scan_left <= 1'b1;
                                    end
                                endcase
                            end
                            default: led <= led;
                        endcase
                    end else begin
                        rate_cnt <= rate_cnt + 3'd1;
                    end
                end
            end
        end
    end

endmodule
